subtractor_serial: RTL and testbench

- Digit-serial multi-cycle subtractor with borrow-in and borrow-out; the inverse operation of the team's adder family.
- Computes d = a - b - bi over WIDTH bits, DIGIT bits per clock, using a start/done handshake.
- Sits beside the adder variants in the arithmetic block set.
- Checked in the same self-checking bench style: reference is a - b - bi, compared against {bo, d}.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/sub_digit.sv | 19 +
 rtl/subtractor_serial.sv | 173 +++++++++++++++++
 tb/tb_subtractor_serial.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM encoding and default sizing.
// Default WIDTH/DIGIT match the adder variants so they line up in the block set.
package arith_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;
  localparam int DEF_N     = DEF_WIDTH / DEF_DIGIT;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Keeps the counter at least one bit wide when a single digit covers the operand.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_N);

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract cell: {bout, diff} = x - y - bin.
// No state; the borrow is the sign bit of a DIGIT+1 bit difference.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] diff_o,
  output logic             bout_o
);

  logic [DIGIT:0] full;

  assign full   = {1'b0, x_i} - {1'b0, y_i} - {{DIGIT{1'b0}}, bin_i};
  assign diff_o = full[DIGIT-1:0];
  assign bout_o = full[DIGIT];

endmodule

// File: rtl/subtractor_serial.sv
// Digit-serial subtractor: d = a - b - bi, DIGIT bits per clock, done pulses N cycles after start.
// Optional signed-overflow output ov is built when SUB_OVERFLOW_EN is defined.
module subtractor_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             done
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ov
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
    $error("subtractor_serial: WIDTH must be a positive multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               brw_q, brw_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bo_q, bo_d;
  logic               done_q, done_d;
`ifdef SUB_OVERFLOW_EN
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               ov_q, ov_d;
`endif

  logic               accept;
  logic               last;
  logic [DIGIT-1:0]   dig_diff;
  logic               dig_bout;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]   res_nxt;

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_sub_digit (
    .x_i    (a_q[DIGIT-1:0]),
    .y_i    (b_q[DIGIT-1:0]),
    .bin_i  (brw_q),
    .diff_o (dig_diff),
    .bout_o (dig_bout)
  );

  // New digits enter at the top so the LSB digit ends up at bit 0 after N shifts.
  assign res_cat = {dig_diff, res_q};
  assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];

  assign accept = ready && start;
  assign last   = (state_q == RUN) && (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    brw_d  = brw_q;
    res_d  = res_q;
    d_d    = d_q;
    bo_d   = bo_q;
    done_d = 1'b0;
`ifdef SUB_OVERFLOW_EN
    sa_d   = sa_q;
    sb_d   = sb_q;
    ov_d   = ov_q;
`endif
    if (accept) begin
      cnt_d = '0;
      a_d   = a;
      b_d   = b;
      brw_d = bi;
      res_d = '0;
`ifdef SUB_OVERFLOW_EN
      sa_d  = a[WIDTH-1];
      sb_d  = b[WIDTH-1];
`endif
    end else if (state_q == RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      brw_d = dig_bout;
      res_d = res_nxt;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        cnt_d  = '0;
        d_d    = res_nxt;
        bo_d   = dig_bout;
        done_d = 1'b1;
`ifdef SUB_OVERFLOW_EN
        ov_d   = (sa_q != sb_q) && (res_nxt[WIDTH-1] != sa_q);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      brw_q  <= 1'b0;
      res_q  <= '0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      ov_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      brw_q  <= brw_d;
      res_q  <= res_d;
      d_q    <= d_d;
      bo_q   <= bo_d;
      done_q <= done_d;
`ifdef SUB_OVERFLOW_EN
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      ov_q   <= ov_d;
`endif
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign done = done_q;
`ifdef SUB_OVERFLOW_EN
  assign ov   = ov_q;
`endif

endmodule

// File: tb/tb_subtractor_serial.sv
// Scoreboard bench for subtractor_serial: driver pushes expected results, monitor pops on done.
// Also checks done latency, single-cycle done, output hold between completions and async reset.
module tb_subtractor_serial;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         ready;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         bi    = 1'b0;
  logic [W-1:0] d;
  logic         bo;
  logic         done;
`ifdef SUB_OVERFLOW_EN
  logic         ov;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    time          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] hold_d  = '0;
  logic         hold_bo = 1'b0;
  logic         prev_done = 1'b0;

  subtractor_serial #(
    .WIDTH (W),
    .DIGIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ready (ready),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .d     (d),
    .bo    (bo),
    .done  (done)
`ifdef SUB_OVERFLOW_EN
    ,
    .ov    (ov)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: one completion per expected entry, exactly 8 cycles (85 time units) after acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        check("done_single_cycle", {63'b0, prev_done}, 64'd0);
        check("ready_at_done", {63'b0, ready}, 64'd1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("d", {32'b0, d}, {32'b0, e.d});
          check("bo", {63'b0, bo}, {63'b0, e.bo});
`ifdef SUB_OVERFLOW_EN
          check("ov", {63'b0, ov}, {63'b0, e.ov});
`endif
          check("latency", 64'($time - e.acc), 64'd85);
          hold_d  = e.d;
          hold_bo = e.bo;
        end
      end else begin
        check("d_hold", {32'b0, d}, {32'b0, hold_d});
        check("bo_hold", {63'b0, bo}, {63'b0, hold_bo});
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                       input logic [W-1:0] ed, input logic ebo, input logic eov,
                       input bit keep_start);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      fail_now("ready_timeout");
      return;
    end
    a     = ta;
    b     = tb;
    bi    = tbi;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back('{ed, ebo, eov, $time});
    @(negedge clk);
    if (!keep_start) start = 1'b0;
  endtask

  task automatic rand_op();
    logic [W-1:0] ra, rb, ed;
    logic         rbi, ebo, eov;
    ra  = $urandom;
    rb  = $urandom;
    rbi = 1'($urandom_range(0, 1));
    {ebo, ed} = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbi};
    eov = (ra[W-1] != rb[W-1]) && (ed[W-1] != ra[W-1]);
    issue(ra, rb, rbi, ed, ebo, eov, 1'b0);
  endtask

  initial begin
    int guard;

    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", {63'b0, ready}, 64'd1);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_d", {32'b0, d}, 64'd0);
    check("rst_bo", {63'b0, bo}, 64'd0);
`ifdef SUB_OVERFLOW_EN
    check("rst_ov", {63'b0, ov}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: a, b, bi, expected d, bo, ov.
    issue(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    issue(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    issue(32'h0000_0055, 32'h0000_0055, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);

    // Start and new operands during RUN must not disturb the op in flight.
    issue(32'h1234_5678, 32'h1234_5679, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 32'hFFFF_FFFF;
    b     = 32'h0000_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-operation: outputs return to reset values at once, no done.
    issue(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEEE, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", {63'b0, ready}, 64'd1);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_d", {32'b0, d}, 64'd0);
    check("midrst_bo", {63'b0, bo}, 64'd0);
    exp_q.delete();
    hold_d  = '0;
    hold_bo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h0000_0010, 32'h0000_0008, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high: second op is accepted in the done cycle.
    issue(32'd100, 32'd1, 1'b0, 32'h0000_0063, 1'b0, 1'b0, 1'b1);
    a = 32'd7;
    b = 32'd9;
    guard = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      fail_now("b2b_done_timeout");
      start = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back('{32'hFFFF_FFFE, 1'b1, 1'b0, $time});
      @(negedge clk);
      start = 1'b0;
    end

    for (int i = 0; i < 1000; i++) begin
      rand_op();
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) fail_now("drain_timeout");
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
